// File: rtl/c3d_pkg.sv
// Shared constants and bank-state encoding for the clip loader.
package c3d_pkg;

    localparam int C3D_WI          = 12;
    localparam int C3D_FRAMES      = 4;
    localparam int C3D_ROWS        = 16;
    localparam int C3D_CLIP_BEATS  = C3D_FRAMES * C3D_ROWS;
    localparam int C3D_ADDR_W      = 8;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_ACTIVE  = 2'd3
    } bank_state_e;

endpackage

// File: rtl/c3d_bank_state.sv
// Ping-pong bank state tracker with an oldest-FULL pointer for start ordering.
//   state        | meaning
//   BANK_EMPTY   | free, may accept the first beat of a clip
//   BANK_FILLING | clip partially written
//   BANK_FULL    | clip complete, waiting for the core
//   BANK_ACTIVE  | core is processing this bank
module c3d_bank_state
    import c3d_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_fill_bank,
    input  logic       i_fill,
    input  logic       i_abort,
    input  logic       i_commit,
    input  logic       i_start,
    input  logic       i_done,
    output logic [1:0] o_state0,
    output logic [1:0] o_state1,
    output logic       o_next_start_bank
);

    bank_state_e r_state [2];
    bank_state_e w_state_nxt [2];
    logic        r_oldest;
    logic        w_oldest_nxt;
    logic [1:0]  w_full;
    logic        w_other_full;

    assign w_full[0]         = (r_state[0] == BANK_FULL);
    assign w_full[1]         = (r_state[1] == BANK_FULL);
    assign w_other_full      = i_fill_bank ? w_full[0] : w_full[1];
    assign o_next_start_bank = (&w_full) ? r_oldest : w_full[1];
    assign o_state0          = r_state[0];
    assign o_state1          = r_state[1];

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_state_nxt[b] = r_state[b];
            case (r_state[b])
                BANK_EMPTY: begin
                    if (i_fill && (i_fill_bank == b[0]) && !i_abort)
                        w_state_nxt[b] = i_commit ? BANK_FULL : BANK_FILLING;
                end
                BANK_FILLING: begin
                    if (i_fill && (i_fill_bank == b[0])) begin
                        if (i_commit)
                            w_state_nxt[b] = BANK_FULL;
                        else if (i_abort)
                            w_state_nxt[b] = BANK_EMPTY;
                    end
                end
                BANK_FULL: begin
                    if (i_start && (o_next_start_bank == b[0]))
                        w_state_nxt[b] = BANK_ACTIVE;
                end
                BANK_ACTIVE: begin
                    if (i_done)
                        w_state_nxt[b] = BANK_EMPTY;
                end
                default: ;
            endcase
        end
    end

    // The pointer only matters while both banks are FULL at once.
    always_comb begin
        w_oldest_nxt = r_oldest;
        if (i_commit && (!w_other_full || i_start))
            w_oldest_nxt = i_fill_bank;
        else if (i_start && (&w_full))
            w_oldest_nxt = ~r_oldest;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state[0] <= BANK_EMPTY;
            r_state[1] <= BANK_EMPTY;
            r_oldest   <= 1'b0;
        end else begin
            r_state[0] <= w_state_nxt[0];
            r_state[1] <= w_state_nxt[1];
            r_oldest   <= w_oldest_nxt;
        end
    end

endmodule

// File: rtl/c3d_clip_loader.sv
// Clip feature-map ingress scheduler: ping-pong frame-buffer fill and CNN start sequencing.
// Optional source stall counter enabled by defining C3D_LOADER_STALL_CNT_EN.
module c3d_clip_loader
    import c3d_pkg::*;
#(
    parameter int WI     = C3D_WI,
    parameter int FRAMES = C3D_FRAMES,
    parameter int ROWS   = C3D_ROWS,
    parameter int ADDR_W = C3D_ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [WI*16-1:0]    s_data,
    input  logic                s_last,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [WI*16-1:0]    wr_data,
    output logic                clip_start,
    output logic                start_bank,
    input  logic                cnn_done,
    output logic                err_last,
    output logic [15:0]         clip_cnt,
    output logic [15:0]         stall_cnt
);

    localparam int BEATS  = FRAMES * ROWS;
    localparam int BEAT_W = $clog2(BEATS);

    logic [BEAT_W-1:0] r_beat;
    logic              r_fill_bank;
    logic [1:0]        w_state0;
    logic [1:0]        w_state1;
    logic [1:0]        w_fill_state;
    logic              w_next_start_bank;
    logic              w_accept;
    logic              w_last_beat;
    logic              w_commit;
    logic              w_abort;
    logic              w_any_active;
    logic              w_any_full;
    logic              w_start;
    logic [ADDR_W-1:0] w_wr_addr;

    assign w_fill_state = r_fill_bank ? w_state1 : w_state0;
    // Gated by reset so every output reads 0 while reset is held.
    assign s_ready      = reset & ((w_fill_state == BANK_EMPTY) | (w_fill_state == BANK_FILLING));
    assign w_accept     = s_valid & s_ready;
    assign w_last_beat  = (r_beat == BEAT_W'(BEATS - 1));
    assign w_commit     = w_accept & w_last_beat;
    assign w_abort      = w_accept & s_last & ~w_last_beat;
    assign w_any_active = (w_state0 == BANK_ACTIVE) | (w_state1 == BANK_ACTIVE);
    assign w_any_full   = (w_state0 == BANK_FULL) | (w_state1 == BANK_FULL);
    assign w_start      = ~w_any_active & w_any_full;
    assign w_wr_addr    = (ADDR_W'(r_fill_bank) << BEAT_W) | ADDR_W'(r_beat);

    c3d_bank_state u_bank_state (
        .clk               (clk),
        .reset             (reset),
        .i_fill_bank       (r_fill_bank),
        .i_fill            (w_accept),
        .i_abort           (w_abort),
        .i_commit          (w_commit),
        .i_start           (w_start),
        .i_done            (cnn_done),
        .o_state0          (w_state0),
        .o_state1          (w_state1),
        .o_next_start_bank (w_next_start_bank)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_beat      <= '0;
            r_fill_bank <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            err_last    <= 1'b0;
            clip_start  <= 1'b0;
            start_bank  <= 1'b0;
            clip_cnt    <= '0;
        end else begin
            wr_en      <= w_accept;
            err_last   <= w_accept & (s_last ^ w_last_beat);
            clip_start <= w_start;
            if (w_accept) begin
                wr_addr <= w_wr_addr;
                wr_data <= s_data;
                if (w_last_beat || s_last)
                    r_beat <= '0;
                else
                    r_beat <= r_beat + 1'b1;
                if (w_last_beat)
                    r_fill_bank <= ~r_fill_bank;
            end
            if (w_start) begin
                start_bank <= w_next_start_bank;
                clip_cnt   <= clip_cnt + 16'd1;
            end
        end
    end

`ifdef C3D_LOADER_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_stall_cnt <= '0;
        else if (s_valid && !s_ready && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_c3d_clip_loader.sv
// Self-checking bench for c3d_clip_loader: vector table, directed corner sequences, random run vs queue model.
module tb_c3d_clip_loader;

    localparam int DW = 192;

    logic           clk;
    logic           reset;
    logic           s_valid;
    logic           s_ready;
    logic [DW-1:0]  s_data;
    logic           s_last;
    logic           wr_en;
    logic [7:0]     wr_addr;
    logic [DW-1:0]  wr_data;
    logic           clip_start;
    logic           start_bank;
    logic           cnn_done;
    logic           err_last;
    logic [15:0]    clip_cnt;
    logic [15:0]    stall_cnt;

    c3d_clip_loader dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .clip_start (clip_start),
        .start_bank (start_bank),
        .cnn_done   (cnn_done),
        .err_last   (err_last),
        .clip_cnt   (clip_cnt),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bank status per bank (0 empty,1 filling,2 full,3 active), commit-order queue.
    int  m_st [2];
    int  m_fill, m_beat, m_cnt, m_stall;
    int  m_q [$];
    bit  e_wr_en, e_err, e_start, e_sb;
    int  e_addr;
    logic [DW-1:0] e_data;
    bit  hold, smp_ready;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return m_st[m_fill] < 2;
    endfunction

    function automatic int exp_stall();
`ifdef C3D_LOADER_STALL_CNT_EN
        return m_stall;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_st[0] = 0; m_st[1] = 0;
        m_fill = 0; m_beat = 0; m_cnt = 0; m_stall = 0;
        m_q.delete();
        e_wr_en = 0; e_err = 0; e_start = 0; e_sb = 0; e_addr = 0; e_data = '0;
    endtask

    task automatic model_step(input bit v, input bit l, input bit d, input logic [DW-1:0] data);
        int  act;
        bit  acc;
        act = -1;
        for (int b = 0; b < 2; b++) if (m_st[b] == 3) act = b;
        acc = v && m_ready();
        if (v && !acc && m_stall < 65535) m_stall++;
        e_start = 0;
        if (act < 0 && m_q.size() > 0) begin
            e_start = 1;
            e_sb    = m_q.pop_front();
            m_st[e_sb] = 3;
            m_cnt   = (m_cnt + 1) % 65536;
        end
        if (d && act >= 0) m_st[act] = 0;
        e_wr_en = acc;
        e_err   = 0;
        if (acc) begin
            e_addr = m_fill * 64 + m_beat;
            e_data = data;
            e_err  = (l != (m_beat == 63));
            if (m_beat == 63) begin
                m_st[m_fill] = 2;
                m_q.push_back(m_fill);
                m_fill = 1 - m_fill;
                m_beat = 0;
            end else if (l) begin
                m_st[m_fill] = 0;
                m_beat = 0;
            end else begin
                m_st[m_fill] = 1;
                m_beat++;
            end
        end
    endtask

    task automatic tick(input bit v, input bit l, input bit d);
        s_valid  = v;
        s_last   = l;
        cnn_done = d;
        if (!hold) s_data = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        #1;
        smp_ready = s_ready;
        chk("s_ready", s_ready, m_ready());
        hold = v && !m_ready();
        model_step(v, l, d, s_data);
        @(posedge clk);
        #1;
        chk("wr_en", wr_en, e_wr_en);
        if (e_wr_en) begin
            chk("wr_addr", wr_addr, e_addr);
            chk("wr_data", wr_data, e_data);
        end
        chk("err_last", err_last, e_err);
        chk("clip_start", clip_start, e_start);
        chk("start_bank", start_bank, e_sb);
        chk("clip_cnt", clip_cnt, m_cnt);
        chk("stall_cnt", stall_cnt, exp_stall());
    endtask

    task automatic send(input int n, input int last_at);
        int got, guard;
        bit r;
        got = 0; guard = 0;
        while (got < n && guard < 400) begin
            r = m_ready();
            tick(1'b1, m_beat == last_at, 1'b0);
            if (r) got++;
            guard++;
        end
        chk("send_budget", got, n);
    endtask

    task automatic do_reset();
        reset = 1'b0; s_valid = 0; s_last = 0; cnn_done = 0;
        #2;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_clip_start", clip_start, 0);
        chk("rst_start_bank", start_bank, 0);
        chk("rst_err_last", err_last, 0);
        chk("rst_clip_cnt", clip_cnt, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        model_reset();
        hold = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    typedef struct {
        bit v, l, d;
        bit x_ready, x_wr_en;
        logic [7:0] x_addr;
        bit x_err, x_start;
    } vec_t;

    vec_t tbl [8];
    int   n_start;

    initial begin
        tbl[0] = '{1, 0, 0, 1, 1, 8'h00, 0, 0};
        tbl[1] = '{1, 0, 0, 1, 1, 8'h01, 0, 0};
        tbl[2] = '{0, 0, 0, 1, 0, 8'h00, 0, 0};
        tbl[3] = '{1, 1, 0, 1, 1, 8'h02, 1, 0};
        tbl[4] = '{1, 0, 0, 1, 1, 8'h00, 0, 0};
        tbl[5] = '{0, 0, 1, 1, 0, 8'h00, 0, 0};
        tbl[6] = '{1, 0, 0, 1, 1, 8'h01, 0, 0};
        tbl[7] = '{1, 1, 0, 1, 1, 8'h02, 1, 0};

        s_data = '0;
        do_reset();

        // Short early-last clips and an ignored cnn_done.
        for (int i = 0; i < 8; i++) begin
            tick(tbl[i].v, tbl[i].l, tbl[i].d);
            chk($sformatf("tbl%0d_ready", i), smp_ready, tbl[i].x_ready);
            chk($sformatf("tbl%0d_wr_en", i), wr_en, tbl[i].x_wr_en);
            if (tbl[i].x_wr_en) chk($sformatf("tbl%0d_addr", i), wr_addr, tbl[i].x_addr);
            chk($sformatf("tbl%0d_err", i), err_last, tbl[i].x_err);
            chk($sformatf("tbl%0d_start", i), clip_start, tbl[i].x_start);
        end

        // Clean clip into bank 0.
        send(64, 63);
        chk("clean_last_addr", wr_addr, 8'h3F);
        chk("clean_no_start_yet", clip_start, 0);
        n_start = 0;
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0);
            if (i == 0) chk("clean_start_1cyc", clip_start, 1);
            n_start += int'(clip_start);
        end
        chk("clean_start_once", n_start, 1);
        chk("clean_start_bank", start_bank, 0);
        chk("clean_clip_cnt", clip_cnt, 1);

        // Ping-pong: bank 1 fills while core holds bank 0.
        send(64, 63);
        chk("pp_last_addr", wr_addr, 8'h7F);
        tick(0, 0, 0);
        chk("pp_not_ready", s_ready, 0);
        for (int i = 0; i < 3; i++) tick(1, 0, 0);
        tick(1, 0, 1);
        chk("pp_done_no_start", clip_start, 0);
        tick(1, 0, 0);
        chk("pp_start", clip_start, 1);
        chk("pp_start_bank", start_bank, 1);
        chk("pp_clip3_wr_en", wr_en, 1);
        chk("pp_clip3_addr", wr_addr, 8'h00);

        // Commit of bank 0 in the same cycle as cnn_done for bank 1.
        send(62, 63);
        tick(1, 1, 1);
        chk("same_commit_addr", wr_addr, 8'h3F);
        chk("same_idle_cycle", clip_start, 0);
        tick(0, 0, 0);
        chk("same_start", clip_start, 1);
        chk("same_start_bank", start_bank, 0);

        // Missing last on beat 63 of bank 1.
        send(64, -1);
        chk("miss_err", err_last, 1);
        tick(0, 0, 1);
        tick(0, 0, 0);
        chk("miss_start", clip_start, 1);
        chk("miss_start_bank", start_bank, 1);

        // Early last on beat 20 of bank 0.
        send(20, -1);
        tick(1, 1, 0);
        chk("early_err", err_last, 1);
        chk("early_addr", wr_addr, 8'd20);
        tick(1, 0, 0);
        chk("early_restart_addr", wr_addr, 8'h00);
        chk("early_no_start", clip_start, 0);

        // Reset in the middle of a fill at beat 30.
        send(29, -1);
        do_reset();
        tick(1, 0, 0);
        chk("rst_first_addr", wr_addr, 8'h00);
        chk("rst_first_wr_en", wr_en, 1);
        chk("rst_clip_cnt_after", clip_cnt, 0);

        // Both banks busy, then 10 stalled valid cycles.
        send(63, 63);
        send(64, 63);
        for (int i = 0; i < 10; i++) tick(1, 0, 0);
`ifdef C3D_LOADER_STALL_CNT_EN
        chk("stall_ten", stall_cnt, 10);
`else
        chk("stall_tied", stall_cnt, 0);
`endif

        // Randomized traffic against the model.
        begin
            bit rv, rl, rd;
            rv = 0; rl = 0;
            for (int i = 0; i < 3000; i++) begin
                if (!hold) begin
                    rv = ($urandom % 10) < 8;
                    if (m_beat == 63) rl = ($urandom % 100) < 90;
                    else              rl = ($urandom % 1000) < 3;
                end
                rd = ($urandom % 100) < 3;
                tick(rv, rl, rd);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
